// File: rtl/dphy_pkg.sv
// Shared types for the D-PHY clock lane: lane state encoding and LP line levels.
// The ULPS states are always enumerated; the controller compiles them in only under DPHY_CLK_ULPS_EN.
package dphy_pkg;

  typedef enum logic [3:0] {
    STOP,
    HS_RQST,
    PREPARE,
    ZERO,
    PRE,
    CLK,
    POST,
    TRAIL,
    EXIT,
    ULPS_RQST,
    ULPS,
    ULPS_EXIT
  } clkLaneState_e;

  // LP line levels, packed as {Dp,Dn}
  localparam logic [1:0] LP11 = 2'b11;
  localparam logic [1:0] LP01 = 2'b01;
  localparam logic [1:0] LP00 = 2'b00;
  localparam logic [1:0] LP10 = 2'b10;

  // The ULPS family ignores lane enable; ULPS is only left through ULPS_EXIT
  function automatic logic isUlpsState(input clkLaneState_e s);
    return (s == ULPS_RQST) || (s == ULPS) || (s == ULPS_EXIT);
  endfunction

endpackage

// File: rtl/dphy_tcnt.sv
// State-duration counter: loads a value on state entry, counts down to zero and holds there.
// A loaded value N expires after N+1 cycles in the state, so 0 gives a one-cycle state.
module dphy_tcnt #(
  parameter int TCNT_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [TCNT_W-1:0] loadVal_i,
  output logic              expired_o
);

  logic [TCNT_W-1:0] cnt_q;
  logic [TCNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = loadVal_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/dphy_clk_lane_ctrl.sv
// D-PHY clock lane controller: LP/HS sequencing and data-lane gating.
// Define DPHY_CLK_ULPS_EN to compile in the ULPS_RQST/ULPS/ULPS_EXIT path.
module dphy_clk_lane_ctrl #(
  parameter int NUM_DATA_LANES = 2,
  parameter int TCNT_W         = 8
) (
  input  logic                      HS_BYTE_CLK,
  input  logic                      TxRst,
  input  logic                      enable,
  input  logic                      TxRequestHS,
  input  logic [TCNT_W-1:0]         T_LPX,
  input  logic [TCNT_W-1:0]         T_PREPARE,
  input  logic [TCNT_W-1:0]         T_ZERO,
  input  logic [TCNT_W-1:0]         T_PRE,
  input  logic [TCNT_W-1:0]         T_POST,
  input  logic [TCNT_W-1:0]         T_TRAIL,
  input  logic [TCNT_W-1:0]         T_EXIT,
  input  logic [TCNT_W-1:0]         T_WAKEUP,
  input  logic                      TX_ULPS_CLK,
  input  logic                      TX_ULPS_Exit,
  input  logic [NUM_DATA_LANES-1:0] DATA_LANE_STP_S,
  output logic [1:0]                LP_DP_DN,
  output logic                      HS_EN,
  output logic                      HS_TOGGLE,
  output logic [NUM_DATA_LANES-1:0] DATA_LANE_START,
  output logic                      STOP_STATE,
  output logic                      ULPS_ACTIVE_NOT
);

  import dphy_pkg::*;

  clkLaneState_e state_q;
  clkLaneState_e state_d;

  logic              cntLoad;
  logic [TCNT_W-1:0] cntLoadVal;
  logic              cntExpired;
  logic              ulpsHold;

  logic [1:0]                lpDpDn_q;
  logic [1:0]                lpDpDn_d;
  logic                      hsEn_q;
  logic                      hsEn_d;
  logic                      hsToggle_q;
  logic                      hsToggle_d;
  logic [NUM_DATA_LANES-1:0] dataLaneStart_q;
  logic [NUM_DATA_LANES-1:0] dataLaneStart_d;
  logic                      stopState_q;
  logic                      stopState_d;
  logic                      ulpsActiveN_d;

`ifdef DPHY_CLK_ULPS_EN
  assign ulpsHold = isUlpsState(state_q);
`else
  logic unusedUlps;
  assign ulpsHold   = 1'b0;
  assign unusedUlps = ^{TX_ULPS_CLK, TX_ULPS_Exit, T_WAKEUP};
`endif

  always_ff @(posedge HS_BYTE_CLK or posedge TxRst) begin
    if (TxRst) begin
      state_q <= STOP;
    end else begin
      state_q <= state_d;
    end
  end

  // Dropping enable aborts any HS/LP sequence straight back to STOP
  always_comb begin
    state_d = state_q;
    if (!enable && !ulpsHold) begin
      state_d = STOP;
    end else begin
      case (state_q)
        STOP: begin
          if (TxRequestHS) begin
            state_d = HS_RQST;
          end
`ifdef DPHY_CLK_ULPS_EN
          else if (TX_ULPS_CLK) begin
            state_d = ULPS_RQST;
          end
`endif
        end
        HS_RQST: if (cntExpired) state_d = PREPARE;
        PREPARE: if (cntExpired) state_d = ZERO;
        ZERO:    if (cntExpired) state_d = PRE;
        PRE:     if (cntExpired) state_d = CLK;
        CLK:     if (!TxRequestHS) state_d = POST;
        POST:    if (cntExpired && (&DATA_LANE_STP_S)) state_d = TRAIL;
        TRAIL:   if (cntExpired) state_d = EXIT;
        EXIT:    if (cntExpired) state_d = STOP;
`ifdef DPHY_CLK_ULPS_EN
        ULPS_RQST: if (cntExpired) state_d = ULPS;
        ULPS:      if (TX_ULPS_Exit) state_d = ULPS_EXIT;
        ULPS_EXIT: if (cntExpired) state_d = STOP;
`endif
        default: state_d = STOP;
      endcase
    end
  end

  // Duration is taken from the T_* value present on the entry cycle
  always_comb begin
    cntLoad    = (state_d != state_q);
    cntLoadVal = '0;
    case (state_d)
      HS_RQST: cntLoadVal = T_LPX;
      PREPARE: cntLoadVal = T_PREPARE;
      ZERO:    cntLoadVal = T_ZERO;
      PRE:     cntLoadVal = T_PRE;
      POST:    cntLoadVal = T_POST;
      TRAIL:   cntLoadVal = T_TRAIL;
      EXIT:    cntLoadVal = T_EXIT;
`ifdef DPHY_CLK_ULPS_EN
      ULPS_RQST: cntLoadVal = T_LPX;
      ULPS_EXIT: cntLoadVal = T_WAKEUP;
`endif
      default: cntLoadVal = '0;
    endcase
  end

  dphy_tcnt #(
    .TCNT_W(TCNT_W)
  ) uTcnt (
    .clk_i    (HS_BYTE_CLK),
    .rst_i    (TxRst),
    .load_i   (cntLoad),
    .loadVal_i(cntLoadVal),
    .expired_o(cntExpired)
  );

  // Outputs decode the next state so the registered pins line up with state_q
  always_comb begin
    lpDpDn_d        = LP00;
    hsEn_d          = 1'b0;
    hsToggle_d      = 1'b0;
    dataLaneStart_d = '0;
    stopState_d     = 1'b0;
    ulpsActiveN_d   = 1'b1;
    case (state_d)
      STOP: begin
        lpDpDn_d    = LP11;
        stopState_d = 1'b1;
      end
      HS_RQST: lpDpDn_d = LP01;
      PREPARE: lpDpDn_d = LP00;
      ZERO:    hsEn_d   = 1'b1;
      PRE: begin
        hsEn_d     = 1'b1;
        hsToggle_d = 1'b1;
      end
      CLK: begin
        hsEn_d          = 1'b1;
        hsToggle_d      = 1'b1;
        dataLaneStart_d = '1;
      end
      POST: begin
        hsEn_d     = 1'b1;
        hsToggle_d = 1'b1;
      end
      TRAIL: hsEn_d   = 1'b1;
      EXIT:  lpDpDn_d = LP11;
`ifdef DPHY_CLK_ULPS_EN
      ULPS_RQST: lpDpDn_d = LP10;
      ULPS: begin
        lpDpDn_d      = LP00;
        ulpsActiveN_d = 1'b0;
      end
      ULPS_EXIT: begin
        lpDpDn_d      = LP10;
        ulpsActiveN_d = 1'b0;
      end
`endif
      default: begin
        lpDpDn_d    = LP11;
        stopState_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge HS_BYTE_CLK or posedge TxRst) begin
    if (TxRst) begin
      lpDpDn_q        <= LP11;
      hsEn_q          <= 1'b0;
      hsToggle_q      <= 1'b0;
      dataLaneStart_q <= '0;
      stopState_q     <= 1'b1;
    end else begin
      lpDpDn_q        <= lpDpDn_d;
      hsEn_q          <= hsEn_d;
      hsToggle_q      <= hsToggle_d;
      dataLaneStart_q <= dataLaneStart_d;
      stopState_q     <= stopState_d;
    end
  end

`ifdef DPHY_CLK_ULPS_EN
  logic ulpsActiveN_q;

  always_ff @(posedge HS_BYTE_CLK or posedge TxRst) begin
    if (TxRst) begin
      ulpsActiveN_q <= 1'b1;
    end else begin
      ulpsActiveN_q <= ulpsActiveN_d;
    end
  end

  assign ULPS_ACTIVE_NOT = ulpsActiveN_q;
`else
  logic unusedUlpsOut;
  assign unusedUlpsOut   = ulpsActiveN_d;
  assign ULPS_ACTIVE_NOT = 1'b1;
`endif

  assign LP_DP_DN        = lpDpDn_q;
  assign HS_EN           = hsEn_q;
  assign HS_TOGGLE       = hsToggle_q;
  assign DATA_LANE_START = dataLaneStart_q;
  assign STOP_STATE      = stopState_q;

endmodule
